dmem_port_arbiter: RTL

Two-requester arbiter in front of the single-port data memory (synchronous write, combinational read, byte/half/word access selected by func3). Requester 0 is the pipeline MEM stage (cpu_*); requester 1 is the debug/loader port (dbg_*). The block grants one access per cycle, gates misaligned stores, and returns registered read data with one-cycle latency. Data memory connects directly to the mem_* ports.

---
 rtl/dmem_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Purpose : arbitrates the CPU MEM stage and the debug/loader port onto one single-port data memory.
// Latency : grant is combinational; rvalid/rdata/err are registered, one cycle after accept.
// Backpr. : a requester holds its request until its ready is high; one access per cycle in total.
//
// Ports:
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   cpu_*_i / cpu_*_o     requester 0 (pipeline MEM stage): valid/we/func3/addr/wdata in,
//                         ready (combinational), rvalid/rdata/err (registered) out
//   dbg_*_i / dbg_*_o     requester 1 (debug/loader), same shape as the CPU port
//   mem_*_o, mem_rdata_i  data memory: synchronous write, combinational read

module dmem_port_arbiter #(
    parameter int unsigned ARB_MODE     = 0,  // 0: CPU priority + starvation guard, 1: round-robin
    parameter int unsigned STARVE_LIMIT = 4   // 1..15, denied dbg cycles before a forced grant
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_valid_i,
    input  logic        cpu_we_i,
    input  logic [2:0]  cpu_func3_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_ready_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_err_o,

    input  logic        dbg_valid_i,
    input  logic        dbg_we_i,
    input  logic [2:0]  dbg_func3_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ready_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic        mem_we_o,
    output logic [2:0]  mem_func3_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Arbitration state
    logic [3:0]  starve_q, starve_d;
    owner_e      last_q, last_d;

    // Grant and selected request
    logic        dbg_wins;
    logic        gnt_cpu, gnt_dbg, gnt_any;
    logic        sel_we;
    logic [2:0]  sel_func3;
    logic [31:0] sel_addr, sel_wdata;
    logic        misaligned;
    logic [31:0] load_data;

    // Response registers
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        cpu_err_q, cpu_err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic        dbg_err_q, dbg_err_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;

    // dbg_wins only matters when both ports request; a lone requester always wins.
    // Grants are forced low during reset so nothing is accepted or written.
    always_comb begin
        dbg_wins = 1'b0;
        if (ARB_MODE == 0) begin
            dbg_wins = (starve_q == STARVE_MAX);
        end else begin
            dbg_wins = (last_q == OWNER_CPU);
        end
        gnt_dbg = ~rst_i & dbg_valid_i & (~cpu_valid_i | dbg_wins);
        gnt_cpu = ~rst_i & cpu_valid_i & ~gnt_dbg;
        gnt_any = gnt_cpu | gnt_dbg;
    end

    // Route the winner to memory; all-zero when idle.
    always_comb begin
        sel_we    = 1'b0;
        sel_func3 = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_dbg) begin
            sel_we    = dbg_we_i;
            sel_func3 = dbg_func3_i;
            sel_addr  = dbg_addr_i;
            sel_wdata = dbg_wdata_i;
        end else if (gnt_cpu) begin
            sel_we    = cpu_we_i;
            sel_func3 = cpu_func3_i;
            sel_addr  = cpu_addr_i;
            sel_wdata = cpu_wdata_i;
        end
    end

    // Halfword needs addr[0]=0, word (and the 11 encoding) needs addr[1:0]=0; bytes always fit.
    assign misaligned = ((sel_func3[1:0] == 2'b01) & sel_addr[0])
                      | (sel_func3[1] & (sel_addr[1:0] != 2'b00));

    assign mem_we_o    = gnt_any & sel_we & ~misaligned;
    assign mem_func3_o = sel_func3;
    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;

    // Stores and faulting accesses return zero data.
    assign load_data = (sel_we | misaligned) ? '0 : mem_rdata_i;

    always_comb begin
        // Counts consecutive denied dbg cycles; a grant or an idle dbg port restarts it.
        starve_d = starve_q;
        if (!dbg_valid_i || gnt_dbg) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end

        last_d = last_q;
        if (gnt_dbg) begin
            last_d = OWNER_DBG;
        end else if (gnt_cpu) begin
            last_d = OWNER_CPU;
        end

        cpu_rvalid_d = gnt_cpu;
        cpu_err_d    = gnt_cpu & misaligned;
        cpu_rdata_d  = gnt_cpu ? load_data : cpu_rdata_q;

        dbg_rvalid_d = gnt_dbg;
        dbg_err_d    = gnt_dbg & misaligned;
        dbg_rdata_d  = gnt_dbg ? load_data : dbg_rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q     <= '0;
            last_q       <= OWNER_DBG;   // CPU wins the first round-robin tie
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            last_q       <= last_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_ready_o  = gnt_cpu;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign cpu_err_o    = cpu_err_q;
    assign cpu_rdata_o  = cpu_rdata_q;

    assign dbg_ready_o  = gnt_dbg;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_err_o    = dbg_err_q;
    assign dbg_rdata_o  = dbg_rdata_q;

endmodule
